// File: rtl/knight_decoder.sv
// knight_decoder: reader side of the knight flasher interface.
// Samples a bouncing one-hot LED pattern on stb, tracks the lit position and
// sweep direction, locks after LOCK_N consecutive legal steps, flags illegal
// samples with a one-cycle err pulse and counts sweep-end reversals while locked.
//
// Ports:
//   ck         clock, all logic on posedge
//   res        synchronous active-high reset (wins over stb)
//   stb        sample strobe; in is evaluated only when stb=1
//   in         flasher pattern, bit WIDTH-1 = top, bit 0 = bottom
//   pos        index of the lit bit last accepted
//   dir        direction of the last accepted move, 1 = up
//   valid      high whenever the decoder is not hunting
//   locked     high while locked
//   err        one-cycle pulse after an illegal sample in SYNC/LOCK
//   sweep_cnt  direction reversals seen while locked, saturating
module knight_decoder #(
    parameter int unsigned  WIDTH  = 8,
    parameter int unsigned  LOCK_N = 4,
    parameter int unsigned  CNTW   = 8,
    localparam int unsigned POSW   = $clog2(WIDTH)
) (
    input  logic             ck,
    input  logic             res,
    input  logic             stb,
    input  logic [WIDTH-1:0] in,
    output logic [POSW-1:0]  pos,
    output logic             dir,
    output logic             valid,
    output logic             locked,
    output logic             err,
    output logic [CNTW-1:0]  sweep_cnt
);

    localparam int unsigned GOODW = 4;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [POSW-1:0]   pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;
    logic              dknown_q, dknown_d;
    logic [GOODW-1:0]  good_q, good_d;
    logic [CNTW-1:0]   sweep_q, sweep_d;

    logic              onehot;
    logic [POSW-1:0]   p;
    logic [POSW-1:0]   exp_pos;
    logic              adjacent;
    logic              hold;
    logic              step_ok;
    logic              mv_up;

    // Sample decode: lit index, neighbourhood and the expected next position
    always_comb begin
        onehot = $onehot(in);
        p      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                p = POSW'(i);
            end
        end

        // Ends of the bar force a bounce regardless of the stored direction
        if (pos_q == POSW'(WIDTH - 1)) begin
            exp_pos = POSW'(WIDTH - 2);
        end else if (pos_q == '0) begin
            exp_pos = POSW'(1);
        end else if (dir_q) begin
            exp_pos = pos_q + POSW'(1);
        end else begin
            exp_pos = pos_q - POSW'(1);
        end

        // No wrap between bit 0 and bit WIDTH-1
        adjacent = ((pos_q != POSW'(WIDTH - 1)) && (p == pos_q + POSW'(1))) ||
                   ((pos_q != '0) && (p == pos_q - POSW'(1)));

        hold    = onehot && (p == pos_q);
        step_ok = onehot && (dknown_q ? (p == exp_pos) : adjacent);
        mv_up   = (p > pos_q);
    end

    // State register
    always_ff @(posedge ck) begin
        if (res) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            err_q    <= 1'b0;
            dknown_q <= 1'b0;
            good_q   <= '0;
            sweep_q  <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            dknown_q <= dknown_d;
            good_q   <= good_d;
            sweep_q  <= sweep_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        dknown_d = dknown_q;
        good_d   = good_q;
        sweep_d  = sweep_q;

        if (stb) begin
            case (state_q)
                HUNT: begin
                    if (onehot) begin
                        state_d  = SYNC;
                        pos_d    = p;
                        good_d   = '0;
                        dknown_d = 1'b0;
                    end
                end
                SYNC, LOCK: begin
                    if (hold) begin
                        state_d = state_q;
                    end else if (step_ok) begin
                        pos_d    = p;
                        dir_d    = mv_up;
                        dknown_d = 1'b1;
                        if (state_q == SYNC) begin
                            good_d = good_q + GOODW'(1);
                            if (good_d == GOODW'(LOCK_N)) begin
                                state_d = LOCK;
                            end
                        end else if ((mv_up != dir_q) && (sweep_q != '1)) begin
                            sweep_d = sweep_q + CNTW'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (onehot) begin
                            // Reseed on the new position and start counting again
                            state_d  = SYNC;
                            pos_d    = p;
                            good_d   = '0;
                            dknown_d = 1'b0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        pos       = pos_q;
        dir       = dir_q;
        err       = err_q;
        sweep_cnt = sweep_q;
        valid     = (state_q != HUNT);
        locked    = (state_q == LOCK);
    end

endmodule

// File: tb/tb_knight_decoder.sv
// Bench for knight_decoder: directed vector table, sweep counter saturation,
// then randomized samples checked against a behavioural model.
module tb_knight_decoder;

    localparam int W      = 8;
    localparam int LOCK_N = 4;
    localparam int CW     = 8;
    localparam int SMAX   = (1 << CW) - 1;

    logic         ck     = 1'b0;
    logic         res    = 1'b0;
    logic         stb    = 1'b0;
    logic [W-1:0] in_sig = '0;
    logic [2:0]   pos;
    logic         dir;
    logic         valid;
    logic         locked;
    logic         err;
    logic [CW-1:0] sweep_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    knight_decoder #(.WIDTH(W), .LOCK_N(LOCK_N), .CNTW(CW)) dut (
        .ck(ck), .res(res), .stb(stb), .in(in_sig),
        .pos(pos), .dir(dir), .valid(valid), .locked(locked),
        .err(err), .sweep_cnt(sweep_cnt)
    );

    always #5 ck = ~ck;

    // Behavioural model
    int m_pos, m_run, m_sweep;
    bit m_dir, m_valid, m_locked, m_err, m_dknown;

    function automatic int idx_of(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Position the bounce should visit next, from the model's view
    function automatic int next_pos();
        if (!m_valid) return 0;
        if (!m_dknown) return (m_pos < W - 1) ? m_pos + 1 : m_pos - 1;
        if (m_pos == W - 1) return W - 2;
        if (m_pos == 0) return 1;
        return m_dir ? m_pos + 1 : m_pos - 1;
    endfunction

    function automatic void m_step(input bit r, input bit s, input logic [W-1:0] v);
        int  p;
        bit  oh;
        bit  legal;
        bit  up;
        m_err = 0;
        if (r) begin
            m_pos = 0; m_dir = 1; m_valid = 0; m_locked = 0;
            m_sweep = 0; m_run = 0; m_dknown = 0;
            return;
        end
        if (!s) return;
        oh = ($countones(v) == 1);
        p  = idx_of(v);
        if (!m_valid) begin
            if (oh) begin
                m_valid = 1; m_pos = p; m_run = 0; m_dknown = 0;
            end
            return;
        end
        if (oh && p == m_pos) return;
        if (!oh) legal = 0;
        else if (!m_dknown) legal = (p == m_pos + 1) || (p == m_pos - 1);
        else legal = (p == next_pos());
        if (legal) begin
            up = (p > m_pos);
            if (m_locked && up != m_dir && m_sweep < SMAX) m_sweep++;
            m_dir = up; m_pos = p; m_dknown = 1;
            if (!m_locked) begin
                m_run++;
                if (m_run == LOCK_N) m_locked = 1;
            end
        end else begin
            m_err = 1; m_locked = 0;
            if (oh) begin
                m_pos = p; m_run = 0; m_dknown = 0;
            end else begin
                m_valid = 0;
            end
        end
    endfunction

    function automatic void chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    task automatic apply(input bit r, input bit s, input logic [W-1:0] v);
        @(negedge ck);
        res = r; stb = s; in_sig = v;
        @(posedge ck);
        m_step(r, s, v);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pos"},    int'(pos),       m_pos);
        chk({tag, ".dir"},    int'(dir),       int'(m_dir));
        chk({tag, ".valid"},  int'(valid),     int'(m_valid));
        chk({tag, ".locked"}, int'(locked),    int'(m_locked));
        chk({tag, ".err"},    int'(err),       int'(m_err));
        chk({tag, ".sweep"},  int'(sweep_cnt), m_sweep);
    endtask

    typedef struct {
        bit           r;
        bit           s;
        logic [W-1:0] v;
        int           e_pos;
        bit           e_dir;
        bit           e_valid;
        bit           e_locked;
        bit           e_err;
        int           e_sweep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit s, input logic [W-1:0] v, input int ep,
                       input bit ed, input bit ev, input bit el, input bit ee, input int es);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.e_pos = ep; t.e_dir = ed;
        t.e_valid = ev; t.e_locked = el; t.e_err = ee; t.e_sweep = es;
        vecs.push_back(t);
    endtask

    initial begin
        // reset
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // climb to lock
        add(0, 1, 8'h01, 0, 1, 1, 0, 0, 0);
        add(0, 1, 8'h02, 1, 1, 1, 0, 0, 0);
        add(0, 1, 8'h04, 2, 1, 1, 0, 0, 0);
        add(0, 1, 8'h08, 3, 1, 1, 0, 0, 0);
        add(0, 1, 8'h10, 4, 1, 1, 1, 0, 0);
        add(0, 1, 8'h20, 5, 1, 1, 1, 0, 0);
        add(0, 1, 8'h40, 6, 1, 1, 1, 0, 0);
        add(0, 1, 8'h80, 7, 1, 1, 1, 0, 0);
        add(0, 1, 8'h40, 6, 0, 1, 1, 0, 1);
        // non-onehot in LOCK: err pulse, back to HUNT
        add(0, 1, 8'h18, 6, 0, 0, 0, 1, 1);
        add(0, 0, 8'h00, 6, 0, 0, 0, 0, 1);
        // relock: seed at 4, climb, bounce at top
        add(0, 1, 8'h10, 4, 0, 1, 0, 0, 1);
        add(0, 1, 8'h20, 5, 1, 1, 0, 0, 1);
        add(0, 1, 8'h40, 6, 1, 1, 0, 0, 1);
        add(0, 1, 8'h80, 7, 1, 1, 0, 0, 1);
        add(0, 1, 8'h40, 6, 0, 1, 1, 0, 1);
        add(0, 1, 8'h20, 5, 0, 1, 1, 0, 1);
        add(0, 1, 8'h10, 4, 0, 1, 1, 0, 1);
        add(0, 1, 8'h08, 3, 0, 1, 1, 0, 1);
        add(0, 1, 8'h04, 2, 0, 1, 1, 0, 1);
        add(0, 1, 8'h02, 1, 0, 1, 1, 0, 1);
        add(0, 1, 8'h01, 0, 0, 1, 1, 0, 1);
        add(0, 1, 8'h02, 1, 1, 1, 1, 0, 2);
        add(0, 1, 8'h04, 2, 1, 1, 1, 0, 2);
        add(0, 1, 8'h08, 3, 1, 1, 1, 0, 2);
        add(0, 1, 8'h10, 4, 1, 1, 1, 0, 2);
        // wrong-way onehot in LOCK: err, reseed at 3
        add(0, 1, 8'h08, 3, 1, 1, 0, 1, 2);
        add(0, 1, 8'h10, 4, 1, 1, 0, 0, 2);
        // garbage without strobe
        add(0, 0, 8'hff, 4, 1, 1, 0, 0, 2);
        add(0, 0, 8'h00, 4, 1, 1, 0, 0, 2);
        add(0, 0, 8'hff, 4, 1, 1, 0, 0, 2);
        add(0, 0, 8'h00, 4, 1, 1, 0, 0, 2);
        add(0, 0, 8'hff, 4, 1, 1, 0, 0, 2);
        // hold, then reset wins over a legal strobe
        add(0, 1, 8'h10, 4, 1, 1, 0, 0, 2);
        add(1, 1, 8'h20, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].v);
            chk($sformatf("v%0d.pos", i),    int'(pos),       vecs[i].e_pos);
            chk($sformatf("v%0d.dir", i),    int'(dir),       int'(vecs[i].e_dir));
            chk($sformatf("v%0d.valid", i),  int'(valid),     int'(vecs[i].e_valid));
            chk($sformatf("v%0d.locked", i), int'(locked),    int'(vecs[i].e_locked));
            chk($sformatf("v%0d.err", i),    int'(err),       int'(vecs[i].e_err));
            chk($sformatf("v%0d.sweep", i),  int'(sweep_cnt), vecs[i].e_sweep);
        end

        // Sweep counter saturation with a clean bounce
        apply(1, 0, 8'h00);
        check_model("sat_rst");
        begin
            int extra = 0;
            for (int n = 0; n < 4000 && extra < 20; n++) begin
                logic [W-1:0] v;
                v = W'(1) << next_pos();
                apply(0, 1, v);
                check_model($sformatf("sat%0d", n));
                if (m_sweep == SMAX) extra++;
            end
        end
        chk("sat_final", int'(sweep_cnt), SMAX);

        // Randomized samples against the model
        for (int n = 0; n < 3000; n++) begin
            int           r;
            logic [W-1:0] v;
            bit           s;
            bit           rs;
            r  = $urandom_range(0, 99);
            s  = 1;
            rs = 0;
            if (r < 55)      v = W'(1) << next_pos();
            else if (r < 65) v = W'(1) << m_pos;
            else if (r < 75) v = W'(1) << $urandom_range(0, W - 1);
            else if (r < 83) v = W'($urandom);
            else if (r < 98) begin
                s = 0; v = W'($urandom);
            end else begin
                rs = 1; v = W'($urandom);
            end
            apply(rs, s, v);
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
